// File: rtl/legv8_multicycle_controller.sv
// LEGv8 multi-cycle control unit.
// Handshake: an instruction transfers on a rising clock edge when
// instr_valid && instr_ready. instr_ready is high only in IDLE, and valid is
// ignored in every other state. The latched word is then sequenced through
// EXEC, an optional STEP2 and MEM_WAIT, and the packed datapath control word
// is decoded each cycle from state + IR. status and mem_ack act only in the
// cycle where they are looked at.
module legv8_multicycle_controller #(
    parameter int K_W         = 64,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      instruction,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [4:0]       status,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic [K_W+30:0]  control_word,
    output logic             busy,
    output logic             fault
);
    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_STEP2, S_MEM_WAIT, S_TRAP} state_t;
    typedef enum logic [3:0] {
        C_BAD, C_B, C_BCOND, C_BL, C_CBZ, C_BR,
        C_D, C_IARITH, C_ILOGIC, C_MOVZ, C_MOVK, C_RALU
    } iclass_t;

    localparam logic [4:0] FS_AND   = 5'b00000;
    localparam logic [4:0] FS_ORR   = 5'b00100;
    localparam logic [4:0] FS_ADD   = 5'b01000;
    localparam logic [4:0] FS_SUB   = 5'b01001;
    localparam logic [4:0] FS_EOR   = 5'b01100;
    localparam logic [4:0] FS_PASSB = 5'b10100;
    localparam logic [4:0] FS_LSL   = 5'b11000;
    localparam logic [4:0] FS_LSR   = 5'b11001;
    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MEM_TIMEOUT);

    state_t           state_q;
    logic [31:0]      ir_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fault_q;
    logic [CNT_W-1:0] cnt_d;
    iclass_t          iclass;

    logic flag_v, flag_c, flag_n, flag_z, flag_zz;
    logic cond_base, cond_true, cbz_true;
    logic [K_W-1:0] k_imm12, k_imm26, k_imm19, k_dt, k_shamt, k_mov, k_movmask;

    // Control word fields
    logic [K_W-1:0] k;
    logic           en_pc, en_ram, en_alu, pc_sel, b_sel, sl, wm, wr, en_b, req;
    logic [1:0]     ps;
    logic [4:0]     fs, sb, sa, da;

    assign {flag_v, flag_c, flag_n, flag_z, flag_zz} = status;
    assign cnt_d = cnt_q + 1'b1;

    assign k_imm12   = {{(K_W-12){1'b0}}, ir_q[21:10]};
    assign k_imm26   = {{(K_W-26){ir_q[25]}}, ir_q[25:0]};
    assign k_imm19   = {{(K_W-19){ir_q[23]}}, ir_q[23:5]};
    assign k_dt      = {{(K_W-9){ir_q[20]}}, ir_q[20:12]};
    assign k_shamt   = {{(K_W-6){1'b0}}, ir_q[15:10]};
    assign k_mov     = {{(K_W-16){1'b0}}, ir_q[20:5]} << {ir_q[22:21], 4'b0000};
    assign k_movmask = ~({{(K_W-16){1'b0}}, 16'hFFFF} << {ir_q[22:21], 4'b0000});

    // Instruction class from opcode field IR[31:21]
    always_comb begin
        iclass = C_BAD;
        if (ir_q[26]) begin
            case (ir_q[31:29])
                3'b000:  iclass = C_B;
                3'b010:  iclass = C_BCOND;
                3'b100:  iclass = C_BL;
                3'b101:  iclass = C_CBZ;
                3'b110:  iclass = C_BR;
                default: iclass = C_BAD;
            endcase
        end else begin
            case (ir_q[25:23])
                3'b000:  iclass = C_D;
                3'b010:  iclass = C_IARITH;
                3'b100:  iclass = C_ILOGIC;
                3'b101:  iclass = ir_q[29] ? C_MOVK : C_MOVZ;
                3'b110:  iclass = C_RALU;
                default: iclass = C_BAD;
            endcase
        end
    end

    // B.cond evaluation; condition 111x is unconditionally taken
    always_comb begin
        case (ir_q[3:1])
            3'b000:  cond_base = flag_z;
            3'b001:  cond_base = flag_c;
            3'b010:  cond_base = flag_n;
            3'b011:  cond_base = flag_v;
            3'b100:  cond_base = flag_c & ~flag_z;
            3'b101:  cond_base = (flag_n == flag_v);
            3'b110:  cond_base = ~flag_z & (flag_n == flag_v);
            default: cond_base = 1'b1;
        endcase
    end
    assign cond_true = (ir_q[3:1] == 3'b111) ? 1'b1 : (cond_base ^ ir_q[0]);
    assign cbz_true  = flag_zz ^ ir_q[24];

    // Sequencer: state, instruction register, memory wait counter, sticky fault
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (instr_valid) begin
                        ir_q    <= instruction;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (iclass)
                        C_BAD: begin
                            state_q <= S_TRAP;
                            fault_q <= 1'b1;
                        end
                        C_BL, C_MOVK: state_q <= S_STEP2;
                        C_D: begin
                            cnt_q   <= '0;
                            state_q <= mem_ack ? S_IDLE : S_MEM_WAIT;
                        end
                        default: state_q <= S_IDLE;
                    endcase
                end
                S_STEP2: state_q <= S_IDLE;
                S_MEM_WAIT: begin
                    if (mem_ack) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_d == TIMEOUT) begin
                            state_q <= S_TRAP;
                            fault_q <= 1'b1;
                        end
                    end
                end
                S_TRAP:  state_q <= S_TRAP;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Control word decode; IDLE, TRAP and undefined classes issue all zeros
    always_comb begin
        k = '0; en_pc = 1'b0; en_ram = 1'b0; en_alu = 1'b0; pc_sel = 1'b0;
        b_sel = 1'b0; sl = 1'b0; wm = 1'b0; wr = 1'b0; en_b = 1'b0; req = 1'b0;
        ps = 2'b00; fs = 5'b00000; sb = 5'd0; sa = 5'd0; da = 5'd0;
        if (state_q == S_EXEC || state_q == S_STEP2 || state_q == S_MEM_WAIT) begin
            case (iclass)
                C_IARITH: begin
                    k = k_imm12; b_sel = 1'b1; en_alu = 1'b1; wr = 1'b1; ps = 2'b01;
                    fs = ir_q[30] ? FS_SUB : FS_ADD; sa = ir_q[9:5]; da = ir_q[4:0];
                end
                C_ILOGIC: begin
                    k = k_imm12; b_sel = 1'b1; en_alu = 1'b1; wr = 1'b1; ps = 2'b01;
                    fs = ir_q[30] ? FS_EOR : (ir_q[29] ? FS_ORR : FS_AND);
                    sa = ir_q[9:5]; da = ir_q[4:0];
                end
                C_RALU: begin
                    k = k_shamt; en_alu = 1'b1; wr = 1'b1; ps = 2'b01; en_b = 1'b1;
                    sb = ir_q[20:16]; sa = ir_q[9:5]; da = ir_q[4:0];
                    if (ir_q[28:27] == 2'b10) begin
                        sl = 1'b1;
                        fs = ir_q[21] ? FS_LSL : FS_LSR;
                    end else begin
                        fs = ir_q[30] ? FS_SUB : FS_ADD;
                    end
                end
                C_MOVZ: begin
                    k = k_mov; b_sel = 1'b1; en_alu = 1'b1; wr = 1'b1; ps = 2'b01;
                    fs = FS_PASSB; da = ir_q[4:0];
                end
                C_MOVK: begin
                    b_sel = 1'b1; en_alu = 1'b1; wr = 1'b1; sa = ir_q[4:0]; da = ir_q[4:0];
                    if (state_q == S_STEP2) begin
                        k = k_mov; fs = FS_ORR; ps = 2'b01;
                    end else begin
                        k = k_movmask; fs = FS_AND; ps = 2'b00;
                    end
                end
                C_B: begin
                    k = k_imm26; ps = 2'b11;
                end
                C_BCOND: begin
                    k = k_imm19; ps = cond_true ? 2'b11 : 2'b01;
                end
                C_CBZ: begin
                    k = k_imm19; en_alu = 1'b1; en_b = 1'b1; fs = FS_PASSB; sb = ir_q[4:0];
                    ps = cbz_true ? 2'b11 : 2'b01;
                end
                C_BR: begin
                    pc_sel = 1'b1; sa = ir_q[9:5]; ps = 2'b10;
                end
                C_BL: begin
                    k = k_imm26;
                    if (state_q == S_STEP2) begin
                        wr = 1'b1; da = 5'd30; ps = 2'b11;
                    end else begin
                        en_pc = 1'b1; ps = 2'b00;
                    end
                end
                C_D: begin
                    k = k_dt; b_sel = 1'b1; en_alu = 1'b1; fs = FS_ADD; en_ram = 1'b1;
                    req = 1'b1; sa = ir_q[9:5];
                    if (ir_q[22]) begin
                        da = ir_q[4:0];
                    end else begin
                        sb = ir_q[4:0]; en_b = 1'b1;
                    end
                    if (mem_ack) begin
                        ps = 2'b01; wr = ir_q[22]; wm = ~ir_q[22];
                    end
                end
                default: ;
            endcase
        end
    end

    assign control_word = {k, en_pc, en_ram, en_alu, pc_sel, b_sel, sl, wm, wr, ps, fs, sb, sa, da, en_b};
    assign mem_req      = req;
    assign instr_ready  = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE) && (state_q != S_TRAP);
    assign fault        = fault_q;

endmodule

// File: tb/tb_legv8_multicycle_controller.sv
// Directed bench for legv8_multicycle_controller: each task drives one
// scenario and compares outputs against hand-computed values.
module tb_legv8_multicycle_controller;
    localparam int K_W  = 64;
    localparam int CW_W = K_W + 31;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [31:0]     instruction = '0;
    logic            instr_valid = 1'b0;
    logic            instr_ready;
    logic [4:0]      status = '0;
    logic            mem_ack = 1'b0;
    logic            mem_req;
    logic [CW_W-1:0] control_word;
    logic            busy;
    logic            fault;

    int n_cmp = 0;
    int n_bad = 0;

    // Hand-encoded instructions
    localparam logic [31:0] I_ADDI = {10'b1001000100, 12'd5, 5'd2, 5'd1};          // ADDI X1,X2,#5
    localparam logic [31:0] I_BEQ  = {8'b01010100, 19'h7FFFE, 1'b0, 4'b0000};      // B.EQ -2
    localparam logic [31:0] I_BNE  = {8'b01010100, 19'd3, 1'b0, 4'b0001};          // B.NE +3
    localparam logic [31:0] I_BGE  = {8'b01010100, 19'd3, 1'b0, 4'b1010};          // B.GE +3
    localparam logic [31:0] I_BAL  = {8'b01010100, 19'd7, 1'b0, 4'b1110};          // B.AL +7
    localparam logic [31:0] I_BL   = {6'b100101, 26'd100};                         // BL +100
    localparam logic [31:0] I_CBZ  = {8'b10110100, 19'd4, 5'd7};                   // CBZ X7
    localparam logic [31:0] I_CBNZ = {8'b10110101, 19'd4, 5'd7};                   // CBNZ X7
    localparam logic [31:0] I_MOVZ = {9'b110100101, 2'b01, 16'h1234, 5'd9};        // MOVZ X9,#0x1234,LSL 16
    localparam logic [31:0] I_MOVK = {9'b111100101, 2'b01, 16'h1234, 5'd9};        // MOVK X9,#0x1234,LSL 16
    localparam logic [31:0] I_LDUR = {11'b11111000010, 9'd8, 2'b00, 5'd4, 5'd3};   // LDUR X3,[X4,#8]
    localparam logic [31:0] I_STUR = {11'b11111000000, 9'h1FF, 2'b00, 5'd6, 5'd5}; // STUR X5,[X6,#-1]
    localparam logic [31:0] I_BAD  = {11'b00000011100, 21'd0};                     // op[4:2]=111

    legv8_multicycle_controller #(.K_W(K_W), .MEM_TIMEOUT(15), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .status(status), .mem_ack(mem_ack), .mem_req(mem_req),
        .control_word(control_word), .busy(busy), .fault(fault)
    );

    // Clock
    always #5 clock = ~clock;

    // Field extraction from the packed control word
    function automatic logic [K_W-1:0] f_k(input logic [CW_W-1:0] cw);  return cw[CW_W-1:31]; endfunction
    function automatic logic f_en_pc(input logic [CW_W-1:0] cw);        return cw[30]; endfunction
    function automatic logic f_wm(input logic [CW_W-1:0] cw);           return cw[24]; endfunction
    function automatic logic f_wr(input logic [CW_W-1:0] cw);           return cw[23]; endfunction
    function automatic logic [1:0] f_ps(input logic [CW_W-1:0] cw);     return cw[22:21]; endfunction
    function automatic logic [4:0] f_sa(input logic [CW_W-1:0] cw);     return cw[10:6]; endfunction
    function automatic logic [4:0] f_da(input logic [CW_W-1:0] cw);     return cw[5:1]; endfunction

    // Driver: wait one edge and land 1 time unit after it
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Driver: present an instruction in IDLE for one cycle; returns in EXEC
    task automatic issue(input logic [31:0] ins);
        instruction = ins;
        instr_valid = 1'b1;
        next_cycle();
        instr_valid = 1'b0;
        instruction = 32'hFFFF_FFFF;
    endtask

    // Driver: asynchronous reset pulse released away from the clock edge
    task automatic do_reset();
        reset = 1'b1;
        mem_ack = 1'b0;
        instr_valid = 1'b0;
        #2;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({instr_ready, busy, mem_req, fault} !== 4'b1000) begin
            n_bad++; $display("FAIL reset_flags: got %b want 1000", {instr_ready, busy, mem_req, fault});
        end
        n_cmp++;
        if (control_word !== '0) begin
            n_bad++; $display("FAIL reset_cw: got %h want 0", control_word);
        end
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_addi();
        instruction = I_ADDI; instr_valid = 1'b1; #1;
        n_cmp++;
        if (instr_ready !== 1'b1 || control_word !== '0) begin
            n_bad++; $display("FAIL idle_before_addi: ready %b cw %h want 1 / 0", instr_ready, control_word);
        end
        next_cycle();
        instr_valid = 1'b0; instruction = 32'hFFFF_FFFF; #1;
        n_cmp++;
        if ({instr_ready, busy} !== 2'b01) begin
            n_bad++; $display("FAIL addi_exec_flags: got %b want 01", {instr_ready, busy});
        end
        n_cmp++;
        if ({f_k(control_word), f_da(control_word), f_sa(control_word), f_wr(control_word), f_ps(control_word)}
            !== {64'd5, 5'd1, 5'd2, 1'b1, 2'b01}) begin
            n_bad++; $display("FAIL addi_word: K %h DA %0d SA %0d WR %b PS %b want 5/1/2/1/01",
                              f_k(control_word), f_da(control_word), f_sa(control_word), f_wr(control_word), f_ps(control_word));
        end
        next_cycle();
        n_cmp++;
        if ({instr_ready, busy} !== 2'b10 || control_word !== '0) begin
            n_bad++; $display("FAIL addi_back_idle: flags %b cw %h want 10 / 0", {instr_ready, busy}, control_word);
        end
    endtask

    task automatic test_bcond();
        issue(I_BEQ); status = 5'b00010; #1;
        n_cmp++;
        if (f_ps(control_word) !== 2'b11 || f_k(control_word) !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            n_bad++; $display("FAIL beq_taken: PS %b K %h want 11 / fffffffffffffffe", f_ps(control_word), f_k(control_word));
        end
        next_cycle();
        issue(I_BEQ); status = 5'b00000; #1;
        n_cmp++;
        if (f_ps(control_word) !== 2'b01) begin
            n_bad++; $display("FAIL beq_not_taken: PS %b want 01", f_ps(control_word));
        end
        next_cycle();
        issue(I_BNE); status = 5'b00010; #1;
        n_cmp++;
        if (f_ps(control_word) !== 2'b01) begin
            n_bad++; $display("FAIL bne_z1: PS %b want 01", f_ps(control_word));
        end
        next_cycle();
        issue(I_BGE); status = 5'b00100; #1;
        n_cmp++;
        if (f_ps(control_word) !== 2'b01) begin
            n_bad++; $display("FAIL bge_n1v0: PS %b want 01", f_ps(control_word));
        end
        next_cycle();
        issue(I_BAL); status = 5'b00000; #1;
        n_cmp++;
        if (f_ps(control_word) !== 2'b11 || f_k(control_word) !== 64'd7) begin
            n_bad++; $display("FAIL bal_zero_status: PS %b K %h want 11 / 7", f_ps(control_word), f_k(control_word));
        end
        status = 5'b11111; #1;
        n_cmp++;
        if (f_ps(control_word) !== 2'b11) begin
            n_bad++; $display("FAIL bal_ones_status: PS %b want 11", f_ps(control_word));
        end
        next_cycle();
        status = 5'b00000;
    endtask

    task automatic test_cbz();
        issue(I_CBZ); status = 5'b00001; #1;
        n_cmp++;
        if (f_ps(control_word) !== 2'b11 || f_k(control_word) !== 64'd4) begin
            n_bad++; $display("FAIL cbz_zz1: PS %b K %h want 11 / 4", f_ps(control_word), f_k(control_word));
        end
        next_cycle();
        issue(I_CBNZ); status = 5'b00001; #1;
        n_cmp++;
        if (f_ps(control_word) !== 2'b01) begin
            n_bad++; $display("FAIL cbnz_zz1: PS %b want 01", f_ps(control_word));
        end
        status = 5'b00000; #1;
        n_cmp++;
        if (f_ps(control_word) !== 2'b11) begin
            n_bad++; $display("FAIL cbnz_zz0: PS %b want 11", f_ps(control_word));
        end
        next_cycle();
    endtask

    task automatic test_two_step();
        issue(I_BL); #1;
        n_cmp++;
        if ({busy, f_en_pc(control_word), f_wr(control_word), f_ps(control_word)} !== 5'b11000) begin
            n_bad++; $display("FAIL bl_step0: busy/EN_PC/WR/PS %b want 11000",
                              {busy, f_en_pc(control_word), f_wr(control_word), f_ps(control_word)});
        end
        next_cycle();
        n_cmp++;
        if ({busy, f_wr(control_word), f_da(control_word), f_ps(control_word)} !== {1'b1, 1'b1, 5'd30, 2'b11}) begin
            n_bad++; $display("FAIL bl_step1: busy %b WR %b DA %0d PS %b want 1/1/30/11",
                              busy, f_wr(control_word), f_da(control_word), f_ps(control_word));
        end
        next_cycle();
        n_cmp++;
        if (instr_ready !== 1'b1) begin
            n_bad++; $display("FAIL bl_ready_third: got %b want 1", instr_ready);
        end
        issue(I_MOVK); #1;
        n_cmp++;
        if (f_ps(control_word) !== 2'b00 || f_k(control_word) !== 64'hFFFF_FFFF_0000_FFFF) begin
            n_bad++; $display("FAIL movk_step0: PS %b K %h want 00 / ffffffff0000ffff", f_ps(control_word), f_k(control_word));
        end
        next_cycle();
        n_cmp++;
        if ({f_wr(control_word), f_ps(control_word), f_da(control_word)} !== {1'b1, 2'b01, 5'd9}
            || f_k(control_word) !== 64'h0000_0000_1234_0000) begin
            n_bad++; $display("FAIL movk_step1: WR %b PS %b DA %0d K %h want 1/01/9/12340000",
                              f_wr(control_word), f_ps(control_word), f_da(control_word), f_k(control_word));
        end
        next_cycle();
        issue(I_MOVZ); #1;
        n_cmp++;
        if ({f_wr(control_word), f_ps(control_word), f_da(control_word)} !== {1'b1, 2'b01, 5'd9}
            || f_k(control_word) !== 64'h0000_0000_1234_0000) begin
            n_bad++; $display("FAIL movz_word: WR %b PS %b DA %0d K %h want 1/01/9/12340000",
                              f_wr(control_word), f_ps(control_word), f_da(control_word), f_k(control_word));
        end
        next_cycle();
        n_cmp++;
        if (instr_ready !== 1'b1) begin
            n_bad++; $display("FAIL movz_single_step: ready %b want 1", instr_ready);
        end
    endtask

    task automatic test_back_to_back();
        instruction = I_BL; instr_valid = 1'b1;
        next_cycle();
        instruction = I_ADDI; #1;
        n_cmp++;
        if (instr_ready !== 1'b0 || f_en_pc(control_word) !== 1'b1) begin
            n_bad++; $display("FAIL b2b_bl_exec: ready %b EN_PC %b want 0 / 1", instr_ready, f_en_pc(control_word));
        end
        next_cycle();
        n_cmp++;
        if (f_da(control_word) !== 5'd30 || f_wr(control_word) !== 1'b1) begin
            n_bad++; $display("FAIL b2b_no_resample: DA %0d WR %b want 30 / 1", f_da(control_word), f_wr(control_word));
        end
        next_cycle();
        n_cmp++;
        if (instr_ready !== 1'b1) begin
            n_bad++; $display("FAIL b2b_idle: ready %b want 1", instr_ready);
        end
        next_cycle();
        instr_valid = 1'b0; #1;
        n_cmp++;
        if ({f_da(control_word), f_sa(control_word), f_wr(control_word)} !== {5'd1, 5'd2, 1'b1}) begin
            n_bad++; $display("FAIL b2b_addi: DA %0d SA %0d WR %b want 1/2/1",
                              f_da(control_word), f_sa(control_word), f_wr(control_word));
        end
        next_cycle();
    endtask

    task automatic test_ldur();
        int n_req;
        logic early_write;
        n_req = 0;
        early_write = 1'b0;
        issue(I_LDUR);
        for (int i = 0; i < 3; i++) begin
            if (mem_req === 1'b1) n_req++;
            if (f_wr(control_word) !== 1'b0 || f_ps(control_word) !== 2'b00) early_write = 1'b1;
            next_cycle();
        end
        n_cmp++;
        if (n_req !== 3 || early_write !== 1'b0) begin
            n_bad++; $display("FAIL ldur_wait: req cycles %0d early write %b want 3 / 0", n_req, early_write);
        end
        mem_ack = 1'b1; #1;
        n_cmp++;
        if ({mem_req, f_wr(control_word), f_wm(control_word), f_ps(control_word)} !== 5'b11001
            || f_k(control_word) !== 64'd8 || f_da(control_word) !== 5'd3) begin
            n_bad++; $display("FAIL ldur_ack: req/WR/WM/PS %b K %h DA %0d want 11001 / 8 / 3",
                              {mem_req, f_wr(control_word), f_wm(control_word), f_ps(control_word)},
                              f_k(control_word), f_da(control_word));
        end
        next_cycle();
        mem_ack = 1'b0; #1;
        n_cmp++;
        if ({instr_ready, mem_req, busy} !== 3'b100) begin
            n_bad++; $display("FAIL ldur_done: ready/req/busy %b want 100", {instr_ready, mem_req, busy});
        end
    endtask

    task automatic test_reset_mid_wait();
        issue(I_STUR);
        next_cycle();
        next_cycle();
        #2;
        reset = 1'b1; #1;
        n_cmp++;
        if (control_word !== '0 || {instr_ready, busy, mem_req, fault} !== 4'b1000) begin
            n_bad++; $display("FAIL reset_mid_wait: cw %h flags %b want 0 / 1000",
                              control_word, {instr_ready, busy, mem_req, fault});
        end
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_stur_timeout();
        int n_busy;
        int n_req;
        logic done;
        logic bad_write;
        n_busy = 0;
        n_req = 0;
        done = 1'b0;
        bad_write = 1'b0;
        issue(I_STUR);
        for (int i = 0; i < 40 && !done; i++) begin
            if (busy !== 1'b1) begin
                done = 1'b1;
            end else begin
                n_busy++;
                if (mem_req === 1'b1) n_req++;
                if (f_wm(control_word) !== 1'b0 || f_ps(control_word) !== 2'b00) bad_write = 1'b1;
                next_cycle();
            end
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++; $display("FAIL stur_timeout_bound: still busy after 40 cycles");
        end
        n_cmp++;
        if (n_busy !== 16 || n_req !== 16 || bad_write !== 1'b0) begin
            n_bad++; $display("FAIL stur_wait_len: busy %0d req %0d bad write %b want 16 / 16 / 0", n_busy, n_req, bad_write);
        end
        n_cmp++;
        if ({fault, instr_ready, busy, mem_req} !== 4'b1000 || control_word !== '0) begin
            n_bad++; $display("FAIL stur_trap: fault/ready/busy/req %b cw %h want 1000 / 0",
                              {fault, instr_ready, busy, mem_req}, control_word);
        end
        instruction = I_ADDI; instr_valid = 1'b1;
        for (int i = 0; i < 4; i++) next_cycle();
        n_cmp++;
        if ({fault, instr_ready, busy} !== 3'b100) begin
            n_bad++; $display("FAIL trap_sticky: fault/ready/busy %b want 100", {fault, instr_ready, busy});
        end
        do_reset();
        n_cmp++;
        if ({fault, instr_ready} !== 2'b01) begin
            n_bad++; $display("FAIL trap_reset_exit: fault/ready %b want 01", {fault, instr_ready});
        end
    endtask

    task automatic test_undefined();
        issue(I_BAD); #1;
        n_cmp++;
        if (control_word !== '0 || fault !== 1'b0) begin
            n_bad++; $display("FAIL undef_exec: cw %h fault %b want 0 / 0", control_word, fault);
        end
        next_cycle();
        n_cmp++;
        if ({fault, instr_ready, busy} !== 3'b100 || control_word !== '0) begin
            n_bad++; $display("FAIL undef_trap: fault/ready/busy %b cw %h want 100 / 0",
                              {fault, instr_ready, busy}, control_word);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_bcond();
        test_cbz();
        test_two_step();
        test_back_to_back();
        test_ldur();
        test_reset_mid_wait();
        test_stur_timeout();
        test_undefined();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
